// File: rtl/lcd_nibble_sequencer_pkg.sv
// Shared definitions for the LCD nibble sequencer: FSM states, power-on init
// table, slow-command codes, plus the ALU opcode set kept in the same package.
package lcd_nibble_sequencer_pkg;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_PASS
  } alu_op_e;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_GAP,
    S_WAIT
  } lcd_state_e;

  typedef enum logic [1:0] {
    WS_INIT1,
    WS_INIT2,
    WS_CMD,
    WS_AUTO
  } wait_sel_e;

  typedef struct packed {
    logic [7:0] data;
    logic       nib_only;
    wait_sel_e  wsel;
  } init_entry_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  localparam logic [3:0] INIT_LAST = 4'd7;

  // Nibble-only entries carry their nibble in data[7:4].
  function automatic init_entry_t init_rom(input logic [3:0] idx);
    init_entry_t e;
    e = '{data: 8'h00, nib_only: 1'b0, wsel: WS_AUTO};
    case (idx)
      4'd0: e = '{data: 8'h30, nib_only: 1'b1, wsel: WS_INIT1};
      4'd1: e = '{data: 8'h30, nib_only: 1'b1, wsel: WS_INIT2};
      4'd2: e = '{data: 8'h30, nib_only: 1'b1, wsel: WS_INIT2};
      4'd3: e = '{data: 8'h20, nib_only: 1'b1, wsel: WS_CMD};
      4'd4: e = '{data: 8'h28, nib_only: 1'b0, wsel: WS_AUTO};
      4'd5: e = '{data: 8'h06, nib_only: 1'b0, wsel: WS_AUTO};
      4'd6: e = '{data: 8'h0C, nib_only: 1'b0, wsel: WS_AUTO};
      4'd7: e = '{data: 8'h01, nib_only: 1'b0, wsel: WS_AUTO};
      default: e = '{data: 8'h00, nib_only: 1'b0, wsel: WS_AUTO};
    endcase
    return e;
  endfunction

  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_nibble_sequencer_delay_counter.sv
// Loadable 20-bit down-counter; done flags the final cycle of a loaded interval.
module lcd_delay_counter #(
  parameter logic [19:0] RESET_VALUE = '0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [19:0] i_value,
  output logic        o_done
);

  logic [19:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= RESET_VALUE;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 20'd1;
    end
  end

  // A load of N gives N cycles; a load of 0 behaves like 1.
  assign o_done = (r_count <= 20'd1);

endmodule

// File: rtl/lcd_nibble_sequencer.sv
// HD44780-style 4-bit LCD write sequencer: power-on init, then one byte per
// valid/ready handshake sent as two enable-strobed nibbles.
module lcd_nibble_sequencer
  import lcd_nibble_sequencer_pkg::*;
#(
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned ENABLE_CYC     = 12,
  parameter int unsigned HOLD_CYC       = 2,
  parameter int unsigned NIB_GAP_CYC    = 50,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 82000,
  parameter int unsigned INIT_WAIT1_CYC = 205000,
  parameter int unsigned INIT_WAIT2_CYC = 5000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oInitDone,
  output logic [3:0] oLCD,
  output logic       oRegisterSelect,
  output logic       oEnable,
  output logic       oReadWrite
);

  localparam logic [19:0] L_POWERUP = 20'(POWERUP_CYC);
  localparam logic [19:0] L_SETUP   = 20'(SETUP_CYC);
  localparam logic [19:0] L_ENABLE  = 20'(ENABLE_CYC);
  localparam logic [19:0] L_HOLD    = 20'(HOLD_CYC);
  localparam logic [19:0] L_GAP     = 20'(NIB_GAP_CYC);
  localparam logic [19:0] L_CMD     = 20'(CMD_WAIT_CYC);
  localparam logic [19:0] L_CLEAR   = 20'(CLEAR_WAIT_CYC);
  localparam logic [19:0] L_INIT1   = 20'(INIT_WAIT1_CYC);
  localparam logic [19:0] L_INIT2   = 20'(INIT_WAIT2_CYC);

  lcd_state_e  r_state, w_state_nxt;
  logic [1:0]  r_sync;
  logic        w_run;
  logic        w_done;
  logic        w_adv;
  logic        w_load;
  logic [19:0] w_load_val;
  logic        w_accept;
  logic [7:0]  r_byte;
  logic        r_rs;
  logic [3:0]  r_nib;
  logic        r_low;
  logic        r_nib_only;
  logic [19:0] r_wait;
  logic [3:0]  r_init_idx;
  logic        r_init_mode;
  logic        r_init_done;
  init_entry_t w_entry;
  logic [19:0] w_entry_wait;

  // Release of the async reset is retimed so the FSM only starts on a clean edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_sync <= '0;
    else        r_sync <= {r_sync[0], 1'b1};
  end
  assign w_run = r_sync[1];

  lcd_delay_counter #(
    .RESET_VALUE(L_POWERUP)
  ) u_delay (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_en    (w_run),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_done  (w_done)
  );

  assign w_adv    = w_run && w_done;
  assign oReady   = (r_state == S_IDLE) && r_init_done;
  assign w_accept = oReady && iValid;

  assign w_entry = init_rom(r_init_idx);
  always_comb begin
    w_entry_wait = L_CMD;
    case (w_entry.wsel)
      WS_INIT1: w_entry_wait = L_INIT1;
      WS_INIT2: w_entry_wait = L_INIT2;
      WS_CMD:   w_entry_wait = L_CMD;
      default:  w_entry_wait = is_slow_cmd(1'b0, w_entry.data) ? L_CLEAR : L_CMD;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = L_SETUP;
    case (r_state)
      S_POWERUP: if (w_adv) w_state_nxt = S_INIT;
      S_INIT: if (w_run) begin
        w_state_nxt = S_SETUP;
        w_load      = 1'b1;
        w_load_val  = L_SETUP;
      end
      S_IDLE: if (w_accept) begin
        w_state_nxt = S_SETUP;
        w_load      = 1'b1;
        w_load_val  = L_SETUP;
      end
      S_SETUP: if (w_adv) begin
        w_state_nxt = S_PULSE;
        w_load      = 1'b1;
        w_load_val  = L_ENABLE;
      end
      S_PULSE: if (w_adv) begin
        w_state_nxt = S_HOLD;
        w_load      = 1'b1;
        w_load_val  = L_HOLD;
      end
      S_HOLD: if (w_adv) begin
        w_load = 1'b1;
        if (!r_low && !r_nib_only) begin
          w_state_nxt = S_GAP;
          w_load_val  = L_GAP;
        end else begin
          w_state_nxt = S_WAIT;
          w_load_val  = r_wait;
        end
      end
      S_GAP: if (w_adv) begin
        w_state_nxt = S_SETUP;
        w_load      = 1'b1;
        w_load_val  = L_SETUP;
      end
      S_WAIT: if (w_adv) begin
        w_state_nxt = (r_init_mode && (r_init_idx != INIT_LAST)) ? S_INIT : S_IDLE;
      end
      default: w_state_nxt = S_POWERUP;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_POWERUP;
      r_byte      <= '0;
      r_rs        <= 1'b0;
      r_nib       <= '0;
      r_low       <= 1'b0;
      r_nib_only  <= 1'b0;
      r_wait      <= '0;
      r_init_idx  <= '0;
      r_init_mode <= 1'b1;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_INIT: if (w_run) begin
          r_byte     <= w_entry.data;
          r_rs       <= 1'b0;
          r_nib      <= w_entry.data[7:4];
          r_low      <= 1'b0;
          r_nib_only <= w_entry.nib_only;
          r_wait     <= w_entry_wait;
        end
        S_IDLE: if (w_accept) begin
          r_byte     <= iData;
          r_rs       <= iRS;
          r_nib      <= iData[7:4];
          r_low      <= 1'b0;
          r_nib_only <= 1'b0;
          r_wait     <= is_slow_cmd(iRS, iData) ? L_CLEAR : L_CMD;
        end
        S_GAP: if (w_adv) begin
          r_low <= 1'b1;
          r_nib <= r_byte[3:0];
        end
        S_WAIT: if (w_adv && r_init_mode) begin
          if (r_init_idx == INIT_LAST) begin
            r_init_mode <= 1'b0;
            r_init_done <= 1'b1;
          end else begin
            r_init_idx <= r_init_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign oInitDone       = r_init_done;
  assign oLCD            = r_nib;
  assign oRegisterSelect = r_rs;
  assign oEnable         = (r_state == S_PULSE);
  assign oReadWrite      = 1'b0;

endmodule
